// File: rtl/bram_line_arbiter.sv
// Purpose: shares one single-port grid-line BRAM between the display fetcher (D, read) and the compute engine (C, read/write).
// Latency: grant is combinational; the command reaches bram_* one cycle later; read data returns RD_LATENCY+1 cycles after grant.
// Backpressure: requesters hold req until gnt; D wins by default, C is forced through after MAX_WAIT denied cycles.
// Optional: define BRAM_ARB_STATS_EN to add grant counters, a worst-case C wait monitor and stats_clr.
module bram_line_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 2048,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  aclk,
  input  logic                  periph_reset,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
`ifdef BRAM_ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [31:0]           d_grant_cnt,
  output logic [31:0]           c_grant_cnt,
  output logic [7:0]            c_max_wait,
`endif
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  bram_we,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic {ST_NORMAL = 1'b0, ST_FORCE_C = 1'b1} arb_state_t;

  arb_state_t            state_q, state_nxt;
  logic [7:0]            wait_q, wait_nxt;
  logic                  bram_owner_c;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_c_q;
  logic [DATA_WIDTH-1:0] d_rdata_q, c_rdata_q;

  // Grant selection, starvation counter and force decision
  always_comb begin
    d_gnt     = 1'b0;
    c_gnt     = 1'b0;
    state_nxt = state_q;
    wait_nxt  = wait_q;
    case (state_q)
      ST_FORCE_C: begin
        if (c_req)      c_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
      end
      default: begin
        if (d_req)      d_gnt = 1'b1;
        else if (c_req) c_gnt = 1'b1;
      end
    endcase
    if (c_gnt)                          wait_nxt = '0;
    else if (c_req && wait_q != 8'hFF)  wait_nxt = wait_q + 8'd1;
    // The forced slot is always a single cycle, whether or not C used it.
    if (state_q == ST_FORCE_C) begin
      state_nxt = ST_NORMAL;
      wait_nxt  = '0;
    end else if (wait_nxt >= WAIT_LIMIT) begin
      state_nxt = ST_FORCE_C;
    end
  end

  // Arbiter state and wait counter registers
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state_q <= ST_NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
    end
  end

  // Register the granted command onto the BRAM port
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
      bram_owner_c <= 1'b0;
    end else begin
      bram_en      <= d_gnt | c_gnt;
      bram_we      <= c_gnt & c_we;
      bram_owner_c <= c_gnt;
      if (c_gnt)      bram_addr <= c_addr;
      else if (d_gnt) bram_addr <= d_addr;
      if (c_gnt && c_we) bram_wdata <= c_wdata;
    end
  end

  // Owner tags follow each issued read for RD_LATENCY cycles
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      tag_vld_q <= '0;
      tag_c_q   <= '0;
    end else begin
      tag_vld_q <= (tag_vld_q << 1) | RD_LATENCY'(bram_en & ~bram_we);
      tag_c_q   <= (tag_c_q << 1) | RD_LATENCY'(bram_owner_c);
    end
  end

  assign d_rvalid = tag_vld_q[RD_LATENCY-1] & ~tag_c_q[RD_LATENCY-1];
  assign c_rvalid = tag_vld_q[RD_LATENCY-1] &  tag_c_q[RD_LATENCY-1];

  // Hold the last returned line per port so rdata stays stable between returns
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      d_rdata_q <= '0;
      c_rdata_q <= '0;
    end else begin
      if (d_rvalid) d_rdata_q <= bram_rdata;
      if (c_rvalid) c_rdata_q <= bram_rdata;
    end
  end

  // In the return cycle the line is passed straight through from the BRAM.
  assign d_rdata = d_rvalid ? bram_rdata : d_rdata_q;
  assign c_rdata = c_rvalid ? bram_rdata : c_rdata_q;

`ifdef BRAM_ARB_STATS_EN
  // Grant counters and worst-case C wait, cleared by stats_clr
  always_ff @(posedge aclk or posedge periph_reset) begin
    if (periph_reset) begin
      d_grant_cnt <= '0;
      c_grant_cnt <= '0;
      c_max_wait  <= '0;
    end else if (stats_clr) begin
      d_grant_cnt <= '0;
      c_grant_cnt <= '0;
      c_max_wait  <= '0;
    end else begin
      if (d_gnt) d_grant_cnt <= d_grant_cnt + 32'd1;
      if (c_gnt) c_grant_cnt <= c_grant_cnt + 32'd1;
      if (wait_nxt > c_max_wait) c_max_wait <= wait_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bram_line_arbiter.sv
// Bench for bram_line_arbiter: scenario tasks drive requests, a transaction-level model predicts grants and returns.
// Latency: read returns expected RDL+1 cycles after grant, in grant order.
// Backpressure: stimulus holds each request until its grant.
module tb_bram_line_arbiter;
  localparam int AW = 11, DW = 2048, RDL = 3, MAXW = 8, NW = DW / 32;

  logic          aclk = 1'b0;
  logic          periph_reset;
  logic          d_req, d_gnt, d_rvalid, c_req, c_we, c_gnt, c_rvalid, bram_we, bram_en;
  logic [AW-1:0] d_addr, c_addr, bram_addr;
  logic [DW-1:0] d_rdata, c_rdata, c_wdata, bram_wdata, bram_rdata;
`ifdef BRAM_ARB_STATS_EN
  logic          stats_clr;
  logic [31:0]   d_grant_cnt, c_grant_cnt;
  logic [7:0]    c_max_wait;
`endif

  always #5 aclk = ~aclk;

  bram_line_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .MAX_WAIT(MAXW)) dut (
    .aclk(aclk), .periph_reset(periph_reset),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
`ifdef BRAM_ARB_STATS_EN
    .stats_clr(stats_clr), .d_grant_cnt(d_grant_cnt), .c_grant_cnt(c_grant_cnt), .c_max_wait(c_max_wait),
`endif
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_en(bram_en),
    .bram_rdata(bram_rdata)
  );

  function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
    logic [DW-1:0] l;
    for (int i = 0; i < NW; i++) l[i*32 +: 32] = ((32'(a) << 16) | 32'(i)) ^ 32'h9E37_79B9;
    return l;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int i = 0; i < NW; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  // Behavioural write-first BRAM with RDL-cycle read latency; junk on idle cycles.
  logic [DW-1:0]          bmem [0:(1<<AW)-1];
  bit                     bw   [0:(1<<AW)-1];
  logic [RDL-1:0][DW-1:0] bpipe;
  always @(posedge aclk) begin
    if (bram_en && bram_we) begin
      bmem[bram_addr] <= bram_wdata;
      bw[bram_addr]   <= 1'b1;
    end
    bpipe <= {bpipe[RDL-2:0], (bram_en && !bram_we) ?
              (bw[bram_addr] ? bmem[bram_addr] : init_line(bram_addr)) : rand_line()};
  end
  assign bram_rdata = bpipe[RDL-1];

  // Transaction-level reference model
  typedef struct { int due; bit is_c; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [int];
  int            n_total = 0, n_pass = 0, cyc = 0;
  int            m_wait, m_max, m_dg, m_cg;
  logic          pg_vld, pg_we;
  logic [AW-1:0] pg_addr;
  logic [DW-1:0] pg_wdata, last_d, last_c;
  logic          exp_d_gnt, exp_c_gnt, exp_en, exp_we, exp_d_rvalid, exp_c_rvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_d_rdata, exp_c_rdata;
  logic          obs_d_gnt, obs_c_gnt, obs_en, obs_we, obs_d_rvalid, obs_c_rvalid;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_d_rdata, obs_c_rdata;

  function automatic logic [DW-1:0] rd_line(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_line(a);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_max = 0; m_dg = 0; m_cg = 0;
    pg_vld = 1'b0; pg_we = 1'b0; pg_addr = '0; pg_wdata = '0;
    last_d = '0; last_c = '0;
    rq.delete();
  endtask

  // One clock cycle: drive, predict, sample at the falling edge, advance the model.
  task automatic tick(input logic dr, input logic [AW-1:0] da, input logic cr,
                      input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    ret_t r;
    d_req = dr; d_addr = da; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    exp_c_gnt = cr && (m_wait >= MAXW || !dr);
    exp_d_gnt = dr && !exp_c_gnt;
    exp_en = pg_vld; exp_we = pg_we; exp_addr = pg_addr; exp_wdata = pg_wdata;
    exp_d_rvalid = 1'b0; exp_c_rvalid = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.is_c) begin exp_c_rvalid = 1'b1; last_c = r.data; end
      else        begin exp_d_rvalid = 1'b1; last_d = r.data; end
    end
    exp_d_rdata = last_d; exp_c_rdata = last_c;
    #4;
    obs_d_gnt = d_gnt; obs_c_gnt = c_gnt; obs_en = bram_en; obs_we = bram_we;
    obs_addr = bram_addr; obs_wdata = bram_wdata; obs_d_rvalid = d_rvalid;
    obs_c_rvalid = c_rvalid; obs_d_rdata = d_rdata; obs_c_rdata = c_rdata;
    pg_vld = exp_d_gnt || exp_c_gnt;
    pg_we  = exp_c_gnt && cw;
    if (pg_vld) begin
      pg_addr = exp_c_gnt ? ca : da;
      if (pg_we) begin
        pg_wdata = cd;
        ref_mem[int'(ca)] = cd;
      end else begin
        r.due = cyc + 1 + RDL; r.is_c = exp_c_gnt; r.data = rd_line(pg_addr);
        rq.push_back(r);
      end
    end
    if (exp_d_gnt) m_dg++;
    if (exp_c_gnt) m_cg++;
    if (exp_c_gnt || m_wait >= MAXW) m_wait = 0;
    else if (cr && m_wait < 255)     m_wait++;
    if (m_wait > m_max) m_max = m_wait;
    cyc++;
    @(posedge aclk); #1;
  endtask

  task automatic apply_reset();
    periph_reset = 1'b1; d_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
    d_addr = '0; c_addr = '0; c_wdata = '0;
`ifdef BRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge aclk);
    #1 periph_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    periph_reset = 1'b1; d_req = 1'b0; c_req = 1'b0; c_we = 1'b0;
    d_addr = '0; c_addr = '0; c_wdata = '0;
`ifdef BRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) @(posedge aclk);
    #1;
    n_total++; if ({bram_en, bram_we} !== 2'b00) $display("FAIL reset_en_we got %b want 00", {bram_en, bram_we}); else n_pass++;
    n_total++; if (bram_addr !== '0) $display("FAIL reset_addr got %h want 0", bram_addr); else n_pass++;
    n_total++; if (bram_wdata !== '0) $display("FAIL reset_wdata got %h want 0", bram_wdata[63:0]); else n_pass++;
    n_total++; if ({d_rvalid, c_rvalid} !== 2'b00) $display("FAIL reset_rvalid got %b want 00", {d_rvalid, c_rvalid}); else n_pass++;
    n_total++; if (d_rdata !== '0 || c_rdata !== '0) $display("FAIL reset_rdata got d=%h c=%h want 0", d_rdata[63:0], c_rdata[63:0]); else n_pass++;
`ifdef BRAM_ARB_STATS_EN
    n_total++; if (d_grant_cnt !== 0 || c_grant_cnt !== 0 || c_max_wait !== 0)
      $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", d_grant_cnt, c_grant_cnt, c_max_wait); else n_pass++;
`endif
    periph_reset = 1'b0;
    model_reset();
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    n_total++; if ({obs_d_gnt, obs_c_gnt, obs_en} !== 3'b000) $display("FAIL idle_after_reset got %b want 000", {obs_d_gnt, obs_c_gnt, obs_en}); else n_pass++;
  endtask

  task automatic test_d_read();
    int n_rv = 0, first_rv = -1, n_crv = 0;
    for (int i = 0; i < RDL + 5; i++) begin
      tick(i < 3, AW'(5), 1'b0, 1'b0, '0, '0);
      n_total++; if ({obs_d_gnt, obs_c_gnt} !== {exp_d_gnt, exp_c_gnt} || obs_d_gnt !== (i < 3))
        $display("FAIL dread_gnt i=%0d got d=%b c=%b want d=%b c=%b", i, obs_d_gnt, obs_c_gnt, exp_d_gnt, exp_c_gnt); else n_pass++;
      if (i >= 1 && i <= 3) begin
        n_total++; if (obs_en !== 1'b1 || obs_we !== 1'b0 || obs_addr !== AW'(5))
          $display("FAIL dread_cmd i=%0d got en=%b we=%b addr=%0d want 1 0 5", i, obs_en, obs_we, obs_addr); else n_pass++;
      end
      n_total++; if (obs_d_rvalid !== exp_d_rvalid || (obs_d_rvalid && obs_d_rdata !== exp_d_rdata))
        $display("FAIL dread_ret i=%0d got v=%b %h want v=%b %h", i, obs_d_rvalid, obs_d_rdata[63:0], exp_d_rvalid, exp_d_rdata[63:0]); else n_pass++;
      if (obs_d_rvalid) begin n_rv++; if (first_rv < 0) first_rv = i; end
      if (obs_c_rvalid) n_crv++;
    end
    n_total++; if (n_rv !== 3 || first_rv !== RDL + 1)
      $display("FAIL dread_count got %0d first %0d want 3 first %0d", n_rv, first_rv, RDL + 1); else n_pass++;
    n_total++; if (n_crv !== 0) $display("FAIL dread_no_crv got %0d want 0", n_crv); else n_pass++;
  endtask

  task automatic test_c_write();
    logic [DW-1:0] ones = '1;
    int n_crv = 0, n_drv = 0;
    tick(1'b0, '0, 1'b1, 1'b1, AW'(10), ones);
    n_total++; if ({obs_d_gnt, obs_c_gnt} !== 2'b01) $display("FAIL cwr_gnt got %b want 01", {obs_d_gnt, obs_c_gnt}); else n_pass++;
    tick(1'b1, AW'(10), 1'b0, 1'b0, '0, '0);
    n_total++; if ({obs_en, obs_we} !== 2'b11 || obs_addr !== AW'(10) || obs_wdata !== ones)
      $display("FAIL cwr_cmd got en=%b we=%b addr=%0d want 1 1 10", obs_en, obs_we, obs_addr); else n_pass++;
    n_total++; if (obs_d_gnt !== 1'b1) $display("FAIL wf_dgnt got %b want 1", obs_d_gnt); else n_pass++;
    for (int i = 0; i < RDL + 2; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
      if (obs_c_rvalid) n_crv++;
      if (obs_d_rvalid) begin
        n_drv++;
        n_total++; if (obs_d_rdata !== ones) $display("FAIL write_first got %h want all ones", obs_d_rdata[63:0]); else n_pass++;
      end
    end
    n_total++; if (n_crv !== 0 || n_drv !== 1) $display("FAIL cwr_rvalids got c=%0d d=%0d want c=0 d=1", n_crv, n_drv); else n_pass++;
  endtask

  task automatic test_contention();
    int last_c = -1, n_c = 0, n_d = 0;
    logic [AW-1:0] da = AW'($urandom_range(0, 2047)), ca = AW'($urandom_range(0, 2047));
    apply_reset();
    for (int i = 0; i < 45 + RDL + 2; i++) begin
      tick(i < 45, da, i < 45, 1'b0, ca, '0);
      n_total++; if ({obs_d_gnt, obs_c_gnt} !== {exp_d_gnt, exp_c_gnt})
        $display("FAIL cont_gnt i=%0d got d=%b c=%b want d=%b c=%b", i, obs_d_gnt, obs_c_gnt, exp_d_gnt, exp_c_gnt); else n_pass++;
      n_total++; if ({obs_d_rvalid, obs_c_rvalid} !== {exp_d_rvalid, exp_c_rvalid} || obs_c_rdata !== exp_c_rdata)
        $display("FAIL cont_ret i=%0d got %b want %b", i, {obs_d_rvalid, obs_c_rvalid}, {exp_d_rvalid, exp_c_rvalid}); else n_pass++;
      if (obs_d_gnt) begin n_d++; da = AW'($urandom_range(0, 2047)); end
      if (obs_c_gnt) begin
        if (last_c >= 0) begin
          n_total++; if (i - last_c !== MAXW + 1) $display("FAIL cont_gap got %0d want %0d", i - last_c, MAXW + 1); else n_pass++;
        end
        last_c = i; n_c++; ca = AW'($urandom_range(0, 2047));
      end
    end
    n_total++; if (n_c !== 45 / (MAXW + 1) || n_d !== 45 - 45 / (MAXW + 1))
      $display("FAIL cont_counts got c=%0d d=%0d want c=%0d d=%0d", n_c, n_d, 45 / (MAXW + 1), 45 - 45 / (MAXW + 1)); else n_pass++;
  endtask

  task automatic test_alternating();
    logic [AW-1:0] da = AW'(3), ca = AW'(7);
    for (int i = 0; i < 30 + RDL + 2; i++) begin
      tick(i < 30, da, i < 30, 1'b0, ca, '0);
      n_total++; if ({obs_d_gnt, obs_c_gnt} !== {exp_d_gnt, exp_c_gnt})
        $display("FAIL alt_gnt i=%0d got d=%b c=%b want d=%b c=%b", i, obs_d_gnt, obs_c_gnt, exp_d_gnt, exp_c_gnt); else n_pass++;
      n_total++; if ({obs_d_rvalid, obs_c_rvalid} !== {exp_d_rvalid, exp_c_rvalid} ||
                     obs_d_rdata !== exp_d_rdata || obs_c_rdata !== exp_c_rdata)
        $display("FAIL alt_ret i=%0d got v=%b d=%h c=%h want v=%b d=%h c=%h", i, {obs_d_rvalid, obs_c_rvalid},
                 obs_d_rdata[63:0], obs_c_rdata[63:0], {exp_d_rvalid, exp_c_rvalid}, exp_d_rdata[63:0], exp_c_rdata[63:0]); else n_pass++;
      if (exp_d_gnt) da = (da == AW'(3)) ? AW'(7) : AW'(3);
      if (exp_c_gnt) ca = (ca == AW'(3)) ? AW'(7) : AW'(3);
    end
  endtask

  task automatic test_random();
    logic          dp = 1'b0, cp = 1'b0, cw = 1'b0;
    logic [AW-1:0] da = '0, ca = '0;
    logic [DW-1:0] cd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!dp) begin dp = ($urandom_range(0, 99) < 55) && i < 390; da = AW'($urandom_range(0, 7)); end
      if (!cp) begin
        cp = ($urandom_range(0, 99) < 60) && i < 390; cw = $urandom_range(0, 1) == 1;
        ca = AW'($urandom_range(0, 7)); cd = rand_line();
      end
      tick(dp, da, cp, cw, ca, cd);
      n_total++; if ({obs_d_gnt, obs_c_gnt} !== {exp_d_gnt, exp_c_gnt})
        $display("FAIL rnd_gnt i=%0d got d=%b c=%b want d=%b c=%b", i, obs_d_gnt, obs_c_gnt, exp_d_gnt, exp_c_gnt); else n_pass++;
      n_total++; if ({obs_en, obs_we} !== {exp_en, exp_we} || (exp_en && obs_addr !== exp_addr) || (exp_we && obs_wdata !== exp_wdata))
        $display("FAIL rnd_cmd i=%0d got en=%b we=%b a=%0d want en=%b we=%b a=%0d", i, obs_en, obs_we, obs_addr, exp_en, exp_we, exp_addr); else n_pass++;
      n_total++; if ({obs_d_rvalid, obs_c_rvalid} !== {exp_d_rvalid, exp_c_rvalid} ||
                     obs_d_rdata !== exp_d_rdata || obs_c_rdata !== exp_c_rdata)
        $display("FAIL rnd_ret i=%0d got v=%b d=%h c=%h want v=%b d=%h c=%h", i, {obs_d_rvalid, obs_c_rvalid},
                 obs_d_rdata[63:0], obs_c_rdata[63:0], {exp_d_rvalid, exp_c_rvalid}, exp_d_rdata[63:0], exp_c_rdata[63:0]); else n_pass++;
      if (exp_d_gnt) dp = 1'b0;
      if (exp_c_gnt) cp = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int n_rv = 0;
    tick(1'b1, AW'(42), 1'b0, 1'b0, '0, '0);
    d_req = 1'b0; c_req = 1'b0;
    #2 periph_reset = 1'b1;
    #1;
    n_total++; if ({bram_en, bram_we, d_rvalid, c_rvalid} !== 4'b0000 || bram_addr !== '0 || bram_wdata !== '0)
      $display("FAIL rstmid_async got en=%b we=%b rv=%b%b addr=%0d want all 0", bram_en, bram_we, d_rvalid, c_rvalid, bram_addr); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      n_total++; if ({bram_en, bram_we, d_rvalid, c_rvalid} !== 4'b0000 || bram_addr !== '0)
        $display("FAIL rstmid_hold i=%0d got en=%b we=%b rv=%b%b want 0", i, bram_en, bram_we, d_rvalid, c_rvalid); else n_pass++;
    end
    periph_reset = 1'b0;
    model_reset();
    for (int i = 0; i < RDL + 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
      if (obs_d_rvalid || obs_c_rvalid) n_rv++;
    end
    n_total++; if (n_rv !== 0) $display("FAIL rstmid_no_rvalid got %0d want 0", n_rv); else n_pass++;
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 90; i++) tick(1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 100), '0);
    n_total++; if (d_grant_cnt !== 32'd80 || d_grant_cnt !== 32'(m_dg))
      $display("FAIL stats_d got %0d want 80", d_grant_cnt); else n_pass++;
    n_total++; if (c_grant_cnt !== 32'd10 || c_grant_cnt !== 32'(m_cg))
      $display("FAIL stats_c got %0d want 10", c_grant_cnt); else n_pass++;
    n_total++; if (c_max_wait !== 8'(MAXW) || c_max_wait !== 8'(m_max))
      $display("FAIL stats_max got %0d want %0d", c_max_wait, MAXW); else n_pass++;
    stats_clr = 1'b1;
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0);
    stats_clr = 1'b0;
    n_total++; if (d_grant_cnt !== 0 || c_grant_cnt !== 0 || c_max_wait !== 0)
      $display("FAIL stats_clr got %0d %0d %0d want 0 0 0", d_grant_cnt, c_grant_cnt, c_max_wait); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_d_read();
    test_c_write();
    test_contention();
    test_alternating();
    test_random();
    test_reset_mid();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bram_line_arbiter.md
Name: bram_line_arbiter

Overview:
- Shares one single-port grid-line BRAM (11-bit line address, 2048-bit line) between two requesters.
- Port D is the display line fetcher feeding pixel_generator: read-only and latency-critical.
- Port C is the life-update compute engine: read and write.
- Fixed priority to D, with a starvation guard that forces one C grant after C has waited too long. Read data is returned through a tag pipeline matched to BRAM read latency.

Parameters:
- ADDR_WIDTH, 11, BRAM line address width.
- DATA_WIDTH, 2048, BRAM line width.
- RD_LATENCY, 1, cycles from registered BRAM address to valid bram_rdata (1..4).
- MAX_WAIT, 8, consecutive cycles C may be denied while requesting before a forced grant (1..255).

Ports:
- aclk  in  1  single clock for all logic.
- periph_reset  in  1  asynchronous, active-high reset.
- d_req  in  1  display read request.
- d_addr  in  ADDR_WIDTH  display line address.
- d_gnt  out  1  display request accepted this cycle.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  DATA_WIDTH  display read line.
- c_req  in  1  compute request.
- c_we  in  1  compute write (1) or read (0).
- c_addr  in  ADDR_WIDTH  compute line address.
- c_wdata  in  DATA_WIDTH  compute write line.
- c_gnt  out  1  compute request accepted this cycle.
- c_rvalid  out  1  c_rdata valid.
- c_rdata  out  DATA_WIDTH  compute read line.
- bram_addr  out  ADDR_WIDTH  BRAM port A address (registered).
- bram_wdata  out  DATA_WIDTH  BRAM port A write data (registered).
- bram_we  out  1  BRAM write enable (registered).
- bram_en  out  1  BRAM enable (registered).
- bram_rdata  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset (async assert, sync release): bram_addr=0, bram_wdata=0, bram_we=0, bram_en=0, d_rvalid=0, c_rvalid=0, d_rdata=0, c_rdata=0, wait counter=0, FSM=NORMAL, tag pipeline cleared. Reset mid-transfer discards in-flight reads; no rvalid is emitted for them after release.
- Handshake: a requester holds req and its address/data stable until it sees gnt high. gnt is combinational from req and FSM state in cycle t. The granted command is registered onto the bram_* outputs at the end of cycle t.
- At most one gnt per cycle. When no request is granted, bram_en=0 and bram_we=0 in the next cycle.
- FSM NORMAL:
  - d_req=1 gives d_gnt=1.
  - Otherwise c_req=1 gives c_gnt=1.
- Wait counter: increments (saturating at 255) each cycle with c_req=1 and c_gnt=0; clears on c_gnt. When the counter reaches MAX_WAIT, FSM goes to FORCE_C.
- FSM FORCE_C: c_gnt=1 if c_req=1, even when d_req=1. d_gnt=0 that cycle. On the next edge, FSM returns to NORMAL and the counter clears. If c_req has dropped, FORCE_C serves D normally and returns to NORMAL.
- Read return:
  - A read granted in cycle t drives bram_addr in cycle t+1.
  - The owner's rvalid is high for exactly one cycle at t+1+RD_LATENCY, with rdata captured from bram_rdata.
  - The owner tag (D or C) travels in a RD_LATENCY-deep shift register.
  - rdata holds its value until the next return to that port.
- Writes (c_we=1) produce no rvalid. Back-to-back grants are fully pipelined, one per cycle.
- Same-address C write followed by D read: the D read in the next grant slot sees the new data (BRAM write-first). The arbiter does no forwarding.

Optional Feature:
- Macro BRAM_ARB_STATS_EN.
- With the macro:
  - Adds outputs d_grant_cnt[31:0], c_grant_cnt[31:0] (wrapping grant counters) and c_max_wait[7:0] (highest wait-counter value seen).
  - Adds input stats_clr; stats_clr=1 zeroes all three on the next edge.
  - All three reset to 0.
- Without the macro: these ports and their logic do not exist, and arbitration is identical.

Test Plan:
- Reset release, d_req=1 with d_addr=5 held 3 cycles, RD_LATENCY=1 -> d_gnt=1 each cycle; bram_addr=5 from the next cycle; d_rvalid pulses 2 cycles after each grant; c_rvalid stays 0.
- c_req=1 write with c_addr=10, c_wdata=all-ones, d_req=0 -> c_gnt=1; next cycle bram_we=1, bram_en=1, bram_addr=10; no c_rvalid.
- d_req and c_req held continuously, MAX_WAIT=8 -> c_gnt high exactly once every 9 cycles; d_gnt high the other 8; c_rvalid follows each c_gnt by RD_LATENCY+1.
- Simultaneous D and C reads alternating addresses 3/7, RD_LATENCY=3 -> returns arrive in grant order; each rdata goes only to its owner's port.
- periph_reset pulsed 1 cycle after a read grant -> all bram_* outputs and rvalids are 0 during reset; no rvalid appears after release.
- With BRAM_ARB_STATS_EN, run the continuous-contention scenario for 90 cycles -> d_grant_cnt=80, c_grant_cnt=10, c_max_wait=8; stats_clr then zeroes all three.
